// File: rtl/asi_arb_pkg.sv
// Shared state type and index helpers for the asi RAM arbiter.
// Optional hold-limit preemption is selected by ASI_ARB_HOLD_LIMIT_EN in asi_ram_arb.
package asi_arb_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

  localparam int unsigned IDX_MAXW = 32;

  function automatic int unsigned onehot_to_idx(input logic [IDX_MAXW-1:0] oh);
    int unsigned idx;
    idx = 0;
    for (int unsigned i = 0; i < IDX_MAXW; i++) begin
      if (oh[i]) idx = i;
    end
    return idx;
  endfunction

  function automatic int unsigned idx_wrap_inc(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/asi_rr_pick.sv
// Combinational round-robin picker: first requester at or after the pointer,
// with wrap, skipping any requester set in the exclude mask.
module asi_rr_pick #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned PTRW = 1
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [PTRW-1:0] i_ptr,
  input  logic [NREQ-1:0] i_excl,
  output logic [NREQ-1:0] o_pick,
  output logic            o_valid
);

  logic [NREQ-1:0] w_cand;

  assign w_cand = i_req & ~i_excl;

  always_comb begin
    int unsigned idx;
    o_pick  = '0;
    o_valid = 1'b0;
    idx     = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = 32'(i_ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!o_valid && w_cand[PTRW'(idx)]) begin
        o_pick[PTRW'(idx)] = 1'b1;
        o_valid            = 1'b1;
      end
    end
  end

endmodule

// File: rtl/asi_ram_arb.sv
// Burst-granular round-robin arbiter and port mux for the asi single-port RAM.
// Define ASI_ARB_HOLD_LIMIT_EN to preempt an owner after MAX_HOLD beats when others wait.
module asi_ram_arb
  import asi_arb_pkg::*;
#(
  parameter int unsigned NREQ       = 2,
  parameter int unsigned AXI_DW     = 128,
  parameter int unsigned AXI_AW     = 32,
  parameter int unsigned AXI_WSTRBW = AXI_DW / 8,
  parameter int unsigned RD_LAT     = 1,
  parameter int unsigned MAX_HOLD   = 16
) (
  input  logic                       usr_clk,
  input  logic                       usr_reset_n,
  input  logic [NREQ-1:0]            req,
  input  logic [NREQ-1:0]            en,
  input  logic [NREQ-1:0]            last,
  input  logic [NREQ-1:0]            we,
  input  logic [NREQ*AXI_AW-1:0]     addr,
  input  logic [NREQ*AXI_DW-1:0]     wdata,
  input  logic [NREQ*AXI_WSTRBW-1:0] wstrb,
  output logic [NREQ-1:0]            grant,
  output logic [NREQ-1:0]            q_valid,
  output logic [AXI_DW-1:0]          q_data,
  output logic                       RAM_CEN,
  output logic [AXI_WSTRBW-1:0]      RAM_WEN,
  output logic [AXI_AW-1:0]          RAM_A,
  output logic [AXI_DW-1:0]          RAM_D,
  input  logic [AXI_DW-1:0]          RAM_Q
);

  localparam int unsigned PTRW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned TAGW = RD_LAT * NREQ;

  arb_state_e              r_state, w_state_nxt;
  logic [NREQ-1:0]         r_grant, w_grant_nxt;
  logic [PTRW-1:0]         r_ptr, w_ptr_nxt, w_pick_ptr;
  logic [NREQ-1:0]         w_pick, w_beat_vec;
  logic                    w_pick_vld, w_beat, w_owner_last, w_owner_req, w_others;
  logic                    w_hold_rel, w_release;
  logic [TAGW-1:0]         r_tag;
  logic [AXI_AW-1:0]       w_a;
  logic [AXI_DW-1:0]       w_d;
  logic [AXI_WSTRBW-1:0]   w_s;
  logic                    w_we;

  assign w_beat_vec   = r_grant & en;
  assign w_beat       = |w_beat_vec;
  assign w_owner_last = |(w_beat_vec & last);
  assign w_owner_req  = |(r_grant & req);
  assign w_others     = |(req & ~r_grant);
  assign w_pick_ptr   = PTRW'(idx_wrap_inc(onehot_to_idx(IDX_MAXW'(w_pick)), NREQ));

  // The current owner is never a candidate when its grant is released.
  asi_rr_pick #(
    .NREQ (NREQ),
    .PTRW (PTRW)
  ) u_pick (
    .i_req   (req),
    .i_ptr   (r_ptr),
    .i_excl  (r_grant),
    .o_pick  (w_pick),
    .o_valid (w_pick_vld)
  );

`ifdef ASI_ARB_HOLD_LIMIT_EN
  localparam int unsigned HOLDW = $clog2(MAX_HOLD + 1);
  localparam int unsigned HSUMW = HOLDW + 1;

  logic [HOLDW-1:0] r_hold;
  logic [HSUMW-1:0] w_hold_sum;
  logic             w_grant_chg;

  // The limit includes the beat presented this cycle so the handover follows it directly.
  assign w_hold_sum  = HSUMW'(r_hold) + HSUMW'(w_beat);
  assign w_hold_rel  = (w_hold_sum >= HSUMW'(MAX_HOLD)) && w_others;
  assign w_grant_chg = (w_grant_nxt != r_grant);

  always_ff @(posedge usr_clk or negedge usr_reset_n) begin
    if (!usr_reset_n) begin
      r_hold <= '0;
    end else if (w_grant_chg) begin
      r_hold <= '0;
    end else if (w_beat && (r_hold < HOLDW'(MAX_HOLD))) begin
      r_hold <= r_hold + HOLDW'(1);
    end
  end
`else
  logic w_unused_hold;

  assign w_unused_hold = (MAX_HOLD != 0);
  assign w_hold_rel    = 1'b0;
`endif

  assign w_release = w_owner_last || !w_owner_req || w_hold_rel;

  always_ff @(posedge usr_clk or negedge usr_reset_n) begin
    if (!usr_reset_n) begin
      r_state <= ARB_IDLE;
      r_grant <= '0;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  // Next-state: grant on any request, hand over on release without an idle bubble.
  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_ptr_nxt   = r_ptr;
    case (r_state)
      ARB_IDLE: begin
        if (w_pick_vld) begin
          w_state_nxt = ARB_BUSY;
          w_grant_nxt = w_pick;
          w_ptr_nxt   = w_pick_ptr;
        end
      end
      ARB_BUSY: begin
        if (w_release) begin
          if (w_pick_vld) begin
            w_grant_nxt = w_pick;
            w_ptr_nxt   = w_pick_ptr;
          end else begin
            w_state_nxt = ARB_IDLE;
            w_grant_nxt = '0;
          end
        end
      end
      default: begin
        w_state_nxt = ARB_IDLE;
        w_grant_nxt = '0;
      end
    endcase
  end

  // Read tags ride a RAM-latency-matched shift pipe, oldest slot on top.
  always_ff @(posedge usr_clk or negedge usr_reset_n) begin
    if (!usr_reset_n) begin
      r_tag <= '0;
    end else begin
      r_tag <= TAGW'({r_tag, (w_beat_vec & ~we)});
    end
  end

  // Owner field select; grant is one-hot so an AND-OR mux suffices.
  always_comb begin
    w_a  = '0;
    w_d  = '0;
    w_s  = '0;
    w_we = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (r_grant[i]) begin
        w_a  = w_a | addr[i*AXI_AW +: AXI_AW];
        w_d  = w_d | wdata[i*AXI_DW +: AXI_DW];
        w_s  = w_s | wstrb[i*AXI_WSTRBW +: AXI_WSTRBW];
        w_we = w_we | we[i];
      end
    end
  end

  assign grant   = r_grant;
  assign q_valid = r_tag[TAGW-1 -: NREQ];
  assign q_data  = RAM_Q;
  assign RAM_CEN = ~w_beat;
  assign RAM_WEN = ~(w_s & {AXI_WSTRBW{w_we & w_beat}});
  assign RAM_A   = w_a;
  assign RAM_D   = w_d;

endmodule
